// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the imem fetch front end.
package fetch_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc,data} FIFO with flush; flush wins over push and pop.
module fetch_fifo2
  import fetch_pkg::*;
#(
  parameter int AW = ADDR_W_DEF,
  parameter int DW = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [AW-1:0] push_pc,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_pc,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count,
  output logic          valid
);

  logic [AW-1:0] pc_q   [FIFO_DEPTH];
  logic [AW-1:0] pc_d   [FIFO_DEPTH];
  logic [DW-1:0] data_q [FIFO_DEPTH];
  logic [DW-1:0] data_d [FIFO_DEPTH];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  always_comb begin
    pc_d     = pc_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]   = push_pc;
        data_d[wr_ptr_q] = push_data;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_pc   = pc_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign count     = count_q;
  assign valid     = (count_q != 2'd0);

endmodule

// File: rtl/imem_fetch.sv
// Sequential instruction fetch from imem with redirect, halt and a 2-word skid FIFO.
// Optional performance counters are built when IMEM_FETCH_PERF_EN is defined.
module imem_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic [1:0] fifo_count;
  logic       fifo_valid;
  logic       redirect_take;
  logic       issue;
  logic       push;
  logic       pop;
  logic [1:0] occupancy;

  always_comb begin
    redirect_take = redirect_valid && ((state_q == ST_RUN) || (state_q == ST_HALTED));
    pop           = fifo_valid && instr_ready && !redirect_take;
    push          = inflight_q && !redirect_take;
    // A word leaving this cycle frees its slot, which sustains one word per cycle.
    occupancy     = fifo_count + {1'b0, inflight_q} - {1'b0, pop};
    issue         = (state_q == ST_RUN) && !halt && !redirect_take
                    && (occupancy < 2'(FIFO_DEPTH));

    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_RUN;
      ST_RUN:     if (halt) state_d = ST_HALTED;
      ST_HALTED:  if (!halt) state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase

    pc_d = pc_q;
    if (redirect_take) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + 1'b1;
    end

    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign mem_cen = ~issue;
  assign mem_wen = 1'b1;
  assign mem_a   = pc_q;

  fetch_fifo2 #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_take),
    .push      (push),
    .push_pc   (inflight_pc_q),
    .push_data (mem_q),
    .pop       (pop),
    .head_pc   (instr_pc),
    .head_data (instr_data),
    .count     (fifo_count),
    .valid     (fifo_valid)
  );

  assign instr_valid = fifo_valid;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (instr_valid && instr_ready && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (instr_valid && !instr_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: the driver loads the expected pc/data stream,
// a negedge monitor pops it on every accepted word.
module tb_imem_fetch;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam logic [AW-1:0] RST_PC = '0;

  logic          clk;
  logic          rst;
  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_q;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  imem_fetch #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_cen        (mem_cen),
    .mem_wen        (mem_wen),
    .mem_a          (mem_a),
    .mem_q          (mem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!mem_cen) mem_q <= mem[mem_a];
  end

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  int   fetch_model = 0;
  int   stall_model = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected stream: consecutive addresses from p, wrapping modulo 2^AW.
  function automatic void restart(input logic [AW-1:0] p);
    logic [AW-1:0] a;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      a = p + AW'(i);
      exp_q.push_back('{pc: a, data: mem[a]});
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [AW-1:0] p);
    int n;
    n = 0;
    while (!(instr_valid && instr_pc == p) && n < 64) begin
      step();
      n++;
    end
    check("wait_pc_reached", 32'(n < 64), 32'd1);
  endtask

  task automatic first_valid_latency(input string name);
    int cyc;
    cyc = 0;
    while (!instr_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check(name, 32'(cyc), 32'd3);
  endtask

  // Monitor: one line per accepted word, checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      fetch_model = 0;
      stall_model = 0;
    end else begin
      check("mem_wen_high", 32'(mem_wen), 32'd1);
      if (halt) check("halt_no_issue", 32'(mem_cen), 32'd1);
      if (instr_valid && instr_ready) fetch_model++;
      if (instr_valid && !instr_ready) stall_model++;
      if (instr_valid && instr_ready && !redirect_valid) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got pc 0x%0h, expected no word", instr_pc);
        end else begin
          e = exp_q.pop_front();
          $display("accept pc=0x%0h data=0x%0h (exp pc=0x%0h data=0x%0h)",
                   instr_pc, instr_data, e.pc, e.data);
          check("acc_pc", 32'(instr_pc), 32'(e.pc));
          check("acc_data", 32'(instr_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 100);
    mem_q          = '0;
    rst            = 1'b1;
    instr_ready    = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    restart(RST_PC);
    repeat (3) step();

    check("rst_mem_cen", 32'(mem_cen), 32'd1);
    check("rst_mem_wen", 32'(mem_wen), 32'd1);
    check("rst_mem_a", 32'(mem_a), 32'(RST_PC));
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", 32'(instr_data), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);

    // Startup latency and streaming throughput
    instr_ready = 1'b1;
    rst = 1'b0;
    first_valid_latency("first_valid_cycle");
    repeat (4) begin
      step();
      check("throughput_valid", 32'(instr_valid), 32'd1);
    end

    // Back-pressure at pc 5 for four cycles
    wait_pc(14'd5);
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_hold_valid", 32'(instr_valid), 32'd1);
      check("bp_hold_pc", 32'(instr_pc), 32'd5);
      check("bp_no_issue", 32'(mem_cen), 32'd1);
      step();
    end
    instr_ready = 1'b1;
    repeat (4) step();

    // Redirect while a request is in flight
    redirect_valid = 1'b1;
    redirect_pc    = 14'h2000;
    restart(14'h2000);
    step();
    redirect_valid = 1'b0;
    #1;
    check("redir_valid_low", 32'(instr_valid), 32'd0);
    check("redir_issue_cen", 32'(mem_cen), 32'd0);
    check("redir_issue_a", 32'(mem_a), 32'h2000);
    repeat (6) step();

    // Address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 14'd16382;
    restart(14'd16382);
    step();
    redirect_valid = 1'b0;
    repeat (8) step();

    // Halt at pc 10 for five cycles
    wait_pc(14'd10);
    halt = 1'b1;
    a0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("halt_cen", 32'(mem_cen), 32'd1);
      if (k == 4) check("halt_drained", 32'(instr_valid), 32'd0);
      step();
    end
    check("halt_buffered_le2", 32'(acc_cnt - a0 <= 2), 32'd1);
    halt = 1'b0;
    repeat (6) step();

    // Reset mid-stream with the FIFO full
    instr_ready = 1'b0;
    repeat (3) step();
    check("full_no_issue", 32'(mem_cen), 32'd1);
    rst = 1'b1;
    restart(RST_PC);
    step();
    check("rst_mid_valid", 32'(instr_valid), 32'd0);
    check("rst_mid_cen", 32'(mem_cen), 32'd1);
    rst = 1'b0;
    instr_ready = 1'b1;
    first_valid_latency("restart_first_valid");
    repeat (4) step();

    // Randomized ready/halt/redirect traffic
    for (int c = 0; c < 400; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = AW'($urandom_range(0, (1 << AW) - 1));
        restart(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end

    instr_ready    = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    step();
    a0 = acc_cnt;
    repeat (10) step();
    check("final_liveness", 32'(acc_cnt - a0 >= 5), 32'd1);

`ifdef IMEM_FETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt, 32'(fetch_model));
    check("perf_stall_cnt", perf_stall_cnt, 32'(stall_model));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
